sprite_draw_scheduler: RTL and testbench
========================================

Name: sprite_draw_scheduler

Overview:
- Per-frame sequencer for the sprite drawing engine: holds a host-written table of NUM_SPRITES entries.
- On each frame_start it walks the table in index order and feeds every enabled, non-empty entry to the engine over the draw_sprite/done_draw level handshake, one sprite at a time.
- Pulses fb_swap when the walk completes.
- Sits between the host register bridge and the sprite drawing engine.

Parameters:
NUM_SPRITES, 16, table entries (power of two, 2..64)
IDX_W, $clog2(NUM_SPRITES), entry index width

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous active-low reset
cfg_write  in  1  table write strobe
cfg_read  in  1  table read strobe
cfg_addr  in  IDX_W+2  {entry, word}
cfg_writedata  in  32  write data
cfg_readdata  out  32  read data, registered
frame_start  in  1  one-cycle frame tick (vsync)
sprite_id  out  16  to engine
sprite_x, sprite_y  out  16 each  to engine
sprite_width, sprite_height  out  16 each  to engine
sprite_address  out  32  to engine
sprite_rotate  out  8  to engine
draw_sprite  out  1  draw request, level
done_draw  in  1  engine idle/done, level
busy  out  1  walk in progress
frame_done  out  1  one-cycle pulse at walk end
fb_swap  out  1  one-cycle pulse, coincident with frame_done
frame_overrun  out  1  sticky flag; cleared by a write to word 3 of entry 0 with bit 31 set
cur_index  out  IDX_W  entry being processed

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; table cleared (all entries disabled).
- Table words per entry:
  - w0 = {y[31:16], x[15:0]}
  - w1 = {height[31:16], width[15:0]}
  - w2 = address
  - w3 = {clr_ovr[31], enable[24], rotate[23:16], id[15:0]}
- Writes take effect next cycle and are allowed during a walk.
- The sprite in flight uses parameters latched at ISSUE.
- Reads: cfg_readdata valid 1 cycle after cfg_read; w3 bit 31 reads 0.
- States:
  - IDLE: frame_start -> SCAN; cur_index=0; busy=1.
  - SCAN: examines entry cur_index, 1 cycle per entry.
    - Entry disabled, or width==0, or height==0: skip; cur_index+1, or FINISH if last index.
    - Otherwise -> ISSUE.
  - ISSUE: latch entry into sprite_* registers; assert draw_sprite -> WAIT_ACK.
  - WAIT_ACK: wait for done_draw==0 (engine accepted) -> WAIT_DONE.
  - WAIT_DONE: wait for done_draw==1 -> RELEASE; draw_sprite=0.
  - RELEASE: 2-cycle hold with draw_sprite low so the engine returns to its wait state. Then:
    - cur_index+1 -> SCAN, or
    - FINISH if the last index has been processed.
  - FINISH: frame_done=1, fb_swap=1 for 1 cycle; busy=0 -> IDLE.
- draw_sprite rises only in ISSUE and falls only on the WAIT_DONE->RELEASE transition.
- sprite_* outputs are stable for the whole time draw_sprite is high.
- frame_start while busy: ignored; frame_overrun set.
- frame_start coincident with FINISH: counts as overrun; the next walk is not started.
- Index wrap: cur_index never wraps; the last entry always ends in FINISH.
- All entries disabled: walk takes NUM_SPRITES SCAN cycles + FINISH.
- Minimum per-sprite overhead beyond engine time: ISSUE 1 + RELEASE 2 cycles.
- Walk latency, all disabled: frame_start -> frame_done = NUM_SPRITES+1 cycles.
- Reset mid-walk: immediate return to IDLE, draw_sprite=0, table cleared.

Optional Feature:
SPRITE_SCHED_WATCHDOG_EN
- With: 24-bit watchdog counter runs in WAIT_ACK/WAIT_DONE and reloads on ISSUE.
  - Reaching 24'hFFFFFF forces draw_sprite=0, sets sticky output sprite_timeout, and goes to RELEASE, continuing the walk.
  - sprite_timeout is cleared by the same clr_ovr write.
- Without: no counter, no sprite_timeout port; the scheduler waits indefinitely on done_draw.

Test Plan:
- Reset, then read all words -> all 0; busy=0, draw_sprite=0.
- Entry 3 = x=10, y=20, w=16, h=8, addr=32'h0800_0000, rot=1, enable; others disabled. frame_start; engine model drops done_draw 2 cycles after draw_sprite and raises it 128 cycles later -> exactly one draw with those values latched; frame_done/fb_swap pulse once; busy low afterwards.
- Entries 0, 5, 15 enabled; entry 7 enabled with width=0 -> draws in order 0, 5, 15; entry 7 skipped; draw_sprite low ≥2 cycles between sprites.
- All entries disabled -> frame_done exactly 17 cycles after frame_start (NUM_SPRITES=16); draw_sprite never rises.
- Second frame_start during a draw -> frame_overrun=1 and the walk is unaffected; write w3 of entry 0 with bit31=1 -> frame_overrun=0.
- Overwrite entry 5 x=99 while entry 5 is in flight -> sprite_x holds the old value until RELEASE; the next frame uses 99.
- Assert Reset mid-WAIT_DONE -> draw_sprite=0 and state IDLE asynchronously; the table reads back 0.

Source files
------------

// File: rtl/sprite_draw_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_draw_scheduler
//
// Per-frame sequencer for the sprite drawing engine. The host fills a table of
// NUM_SPRITES entries through a small register port. On every frame_start
// tick the table is walked in index order. Each enabled entry with non-zero
// width and height is handed to the engine over the draw_sprite/done_draw
// level handshake, one sprite at a time. When the walk ends, frame_done and
// fb_swap pulse together for one cycle.
//
// Table layout, four 32-bit words per entry, cfg_addr_i = {entry, word}:
//   w0 = {y[31:16], x[15:0]}
//   w1 = {height[31:16], width[15:0]}
//   w2 = address
//   w3 = {clr_ovr[31], enable[24], rotate[23:16], id[15:0]}
//        clr_ovr is write-only and always reads back as 0.
//
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   cfg_write_i, cfg_read_i          table write / read strobes
//   cfg_addr_i, cfg_writedata_i      table address and write data
//   cfg_readdata_o                   read data, valid one cycle after cfg_read_i
//   frame_start_i                    one-cycle frame tick (vsync)
//   sprite_*_o                       sprite parameters presented to the engine
//   draw_sprite_o / done_draw_i      level handshake with the engine
//   busy_o                           a walk is in progress
//   frame_done_o, fb_swap_o          one-cycle pulses at the end of a walk
//   frame_overrun_o                  sticky; set by frame_start_i while not idle
//   cur_index_o                      table entry currently being processed
//
// Optional feature macro: SPRITE_SCHED_WATCHDOG_EN
//   Adds a 24-bit watchdog on the engine handshake and a sticky
//   sprite_timeout_o output. Both sticky flags are cleared by writing word 3
//   of entry 0 with bit 31 set.
// ---------------------------------------------------------------------------
module sprite_draw_scheduler #(
    parameter int NUM_SPRITES = 16,
    parameter int IDX_W       = $clog2(NUM_SPRITES)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_write_i,
    input  logic               cfg_read_i,
    input  logic [IDX_W+1:0]   cfg_addr_i,
    input  logic [31:0]        cfg_writedata_i,
    output logic [31:0]        cfg_readdata_o,
    input  logic               frame_start_i,
    output logic [15:0]        sprite_id_o,
    output logic [15:0]        sprite_x_o,
    output logic [15:0]        sprite_y_o,
    output logic [15:0]        sprite_width_o,
    output logic [15:0]        sprite_height_o,
    output logic [31:0]        sprite_address_o,
    output logic [7:0]         sprite_rotate_o,
    output logic               draw_sprite_o,
    input  logic               done_draw_i,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic               fb_swap_o,
    output logic               frame_overrun_o,
    output logic [IDX_W-1:0]   cur_index_o
`ifdef SPRITE_SCHED_WATCHDOG_EN
    ,
    output logic               sprite_timeout_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_RELEASE,
        S_FINISH
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    // Sprite table storage
    logic [31:0] pos_q  [NUM_SPRITES];
    logic [31:0] size_q [NUM_SPRITES];
    logic [31:0] addr_q [NUM_SPRITES];
    logic [24:0] attr_q [NUM_SPRITES];

    logic [IDX_W-1:0] cfg_entry;
    logic [1:0]       cfg_word;
    logic [31:0]      rd_data;
    logic [31:0]      cfg_readdata_q;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rel_q, rel_d;
    logic             draw_q, draw_d;
    logic             latch_issue;
    logic             entry_valid;
    logic             clr_flags;
    logic             overrun_q;

    logic [15:0] spr_id_q, spr_x_q, spr_y_q, spr_w_q, spr_h_q;
    logic [31:0] spr_addr_q;
    logic [7:0]  spr_rot_q;

`ifdef SPRITE_SCHED_WATCHDOG_EN
    logic [23:0] wdog_q, wdog_d;
    logic        timeout_hit;
    logic        timeout_q;
`endif

    assign cfg_entry = cfg_addr_i[IDX_W+1:2];
    assign cfg_word  = cfg_addr_i[1:0];
    assign clr_flags = cfg_write_i && (cfg_entry == '0) && (cfg_word == 2'd3)
                       && cfg_writedata_i[31];

    // Host writes to the table; allowed at any time, including during a walk.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                pos_q[i]  <= '0;
                size_q[i] <= '0;
                addr_q[i] <= '0;
                attr_q[i] <= '0;
            end
        end else if (cfg_write_i) begin
            case (cfg_word)
                2'd0:    pos_q[cfg_entry]  <= cfg_writedata_i;
                2'd1:    size_q[cfg_entry] <= cfg_writedata_i;
                2'd2:    addr_q[cfg_entry] <= cfg_writedata_i;
                default: attr_q[cfg_entry] <= cfg_writedata_i[24:0];
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (cfg_word)
            2'd0:    rd_data = pos_q[cfg_entry];
            2'd1:    rd_data = size_q[cfg_entry];
            2'd2:    rd_data = addr_q[cfg_entry];
            default: rd_data = {7'd0, attr_q[cfg_entry]};
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_readdata_q <= '0;
        end else if (cfg_read_i) begin
            cfg_readdata_q <= rd_data;
        end
    end

    // An entry is drawn only if it is enabled and has a non-empty footprint.
    assign entry_valid = attr_q[idx_q][24] && (size_q[idx_q][15:0] != 16'd0)
                         && (size_q[idx_q][31:16] != 16'd0);

`ifdef SPRITE_SCHED_WATCHDOG_EN
    assign timeout_hit = ((state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE))
                         && (wdog_q == 24'hFFFFFF);
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rel_d       = rel_q;
        draw_d      = draw_q;
        latch_issue = 1'b0;
`ifdef SPRITE_SCHED_WATCHDOG_EN
        wdog_d      = wdog_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (entry_valid) begin
                    state_d = S_ISSUE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_ISSUE: begin
                latch_issue = 1'b1;
                draw_d      = 1'b1;
                state_d     = S_WAIT_ACK;
`ifdef SPRITE_SCHED_WATCHDOG_EN
                wdog_d      = '0;
`endif
            end
            S_WAIT_ACK: begin
`ifdef SPRITE_SCHED_WATCHDOG_EN
                wdog_d = wdog_q + 24'd1;
`endif
                if (!done_draw_i) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
`ifdef SPRITE_SCHED_WATCHDOG_EN
                wdog_d = wdog_q + 24'd1;
`endif
                if (done_draw_i) begin
                    draw_d  = 1'b0;
                    rel_d   = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Two cycles with draw_sprite low so the engine can re-arm.
                if (rel_q) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_SCAN;
                    end
                end else begin
                    rel_d = 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef SPRITE_SCHED_WATCHDOG_EN
        // An unresponsive engine is abandoned and the walk carries on.
        if (timeout_hit) begin
            draw_d  = 1'b0;
            rel_d   = 1'b0;
            state_d = S_RELEASE;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rel_q   <= 1'b0;
            draw_q  <= 1'b0;
`ifdef SPRITE_SCHED_WATCHDOG_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rel_q   <= rel_d;
            draw_q  <= draw_d;
`ifdef SPRITE_SCHED_WATCHDOG_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    // Parameters are captured at issue so later host writes cannot disturb
    // the sprite in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spr_id_q   <= '0;
            spr_x_q    <= '0;
            spr_y_q    <= '0;
            spr_w_q    <= '0;
            spr_h_q    <= '0;
            spr_addr_q <= '0;
            spr_rot_q  <= '0;
        end else if (latch_issue) begin
            spr_id_q   <= attr_q[idx_q][15:0];
            spr_x_q    <= pos_q[idx_q][15:0];
            spr_y_q    <= pos_q[idx_q][31:16];
            spr_w_q    <= size_q[idx_q][15:0];
            spr_h_q    <= size_q[idx_q][31:16];
            spr_addr_q <= addr_q[idx_q];
            spr_rot_q  <= attr_q[idx_q][23:16];
        end
    end

    // A frame tick that arrives while not idle (FINISH included) is dropped
    // and flagged. A new overrun wins over a clear in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_q <= 1'b0;
        end else if (frame_start_i && (state_q != S_IDLE)) begin
            overrun_q <= 1'b1;
        end else if (clr_flags) begin
            overrun_q <= 1'b0;
        end
    end

`ifdef SPRITE_SCHED_WATCHDOG_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_q <= 1'b1;
        end else if (clr_flags) begin
            timeout_q <= 1'b0;
        end
    end

    assign sprite_timeout_o = timeout_q;
`endif

    assign cfg_readdata_o   = cfg_readdata_q;
    assign sprite_id_o      = spr_id_q;
    assign sprite_x_o       = spr_x_q;
    assign sprite_y_o       = spr_y_q;
    assign sprite_width_o   = spr_w_q;
    assign sprite_height_o  = spr_h_q;
    assign sprite_address_o = spr_addr_q;
    assign sprite_rotate_o  = spr_rot_q;
    assign draw_sprite_o    = draw_q;
    assign busy_o           = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign frame_done_o     = (state_q == S_FINISH);
    assign fb_swap_o        = (state_q == S_FINISH);
    assign frame_overrun_o  = overrun_q;
    assign cur_index_o      = idx_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sprite_draw_scheduler
//
// Directed bench for sprite_draw_scheduler with NUM_SPRITES = 16. An engine
// model answers the draw handshake. It drops done_draw two cycles after it
// sees draw_sprite and raises it again 128 cycles later. A monitor logs every
// issued sprite, the low gap between draws, parameter stability while
// draw_sprite is high, and the frame_done/fb_swap pulses.
// ---------------------------------------------------------------------------
module tb_sprite_draw_scheduler;

   localparam int NUM_SPRITES = 16;
   localparam int IDX_W       = 4;
   localparam int ENG_LEN     = 128;

   typedef struct {
      logic [15:0] id;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] w;
      logic [15:0] h;
      logic [31:0] addr;
      logic [7:0]  rot;
   } draw_rec_t;

   logic              clk;
   logic              rstN;
   logic              cfgWrite;
   logic              cfgRead;
   logic [IDX_W+1:0]  cfgAddr;
   logic [31:0]       cfgWritedata;
   logic [31:0]       cfgReaddata;
   logic              frameStart;
   logic [15:0]       spriteId, spriteX, spriteY, spriteWidth, spriteHeight;
   logic [31:0]       spriteAddress;
   logic [7:0]        spriteRotate;
   logic              drawSprite;
   logic              doneDraw;
   logic              busy;
   logic              frameDone;
   logic              fbSwap;
   logic              frameOverrun;
   logic [IDX_W-1:0]  curIndex;

   int errors = 0;
   int checks = 0;

   draw_rec_t drawLog[$];
   draw_rec_t saved;
   int        rises = 0;
   int        stabErr = 0;
   int        swapErr = 0;
   int        fdCount = 0;
   int        lowRun = 0;
   int        minGap = 1000;
   bit        haveFall = 0;
   bit        prevDraw = 0;

   sprite_draw_scheduler #(.NUM_SPRITES(NUM_SPRITES)) dut (
      .clk_i           (clk),
      .rst_ni          (rstN),
      .cfg_write_i     (cfgWrite),
      .cfg_read_i      (cfgRead),
      .cfg_addr_i      (cfgAddr),
      .cfg_writedata_i (cfgWritedata),
      .cfg_readdata_o  (cfgReaddata),
      .frame_start_i   (frameStart),
      .sprite_id_o     (spriteId),
      .sprite_x_o      (spriteX),
      .sprite_y_o      (spriteY),
      .sprite_width_o  (spriteWidth),
      .sprite_height_o (spriteHeight),
      .sprite_address_o(spriteAddress),
      .sprite_rotate_o (spriteRotate),
      .draw_sprite_o   (drawSprite),
      .done_draw_i     (doneDraw),
      .busy_o          (busy),
      .frame_done_o    (frameDone),
      .fb_swap_o       (fbSwap),
      .frame_overrun_o (frameOverrun),
      .cur_index_o     (curIndex)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Engine model: accept on draw_sprite, go busy 2 cycles later, finish
   // ENG_LEN cycles after that, then wait for draw_sprite to drop
   initial begin : engine
      int  engCnt;
      bit  engActive;
      engCnt    = 0;
      engActive = 1'b0;
      doneDraw  = 1'b1;
      forever begin
         @(negedge clk);
         if (!rstN) begin
            engActive = 1'b0;
            engCnt    = 0;
            doneDraw  = 1'b1;
         end else if (!engActive) begin
            if (drawSprite && doneDraw) begin
               engActive = 1'b1;
               engCnt    = 0;
            end
         end else begin
            engCnt++;
            if (engCnt == 2) doneDraw = 1'b0;
            else if (engCnt == 2 + ENG_LEN) doneDraw = 1'b1;
            else if (engCnt > 2 + ENG_LEN && !drawSprite) engActive = 1'b0;
         end
      end
   end

   // Monitor: log issued sprites, draw-low gaps, stability and pulses
   initial begin : monitor
      draw_rec_t cur;
      forever begin
         @(negedge clk);
         cur.id   = spriteId;
         cur.x    = spriteX;
         cur.y    = spriteY;
         cur.w    = spriteWidth;
         cur.h    = spriteHeight;
         cur.addr = spriteAddress;
         cur.rot  = spriteRotate;
         if (drawSprite) begin
            if (!prevDraw) begin
               rises++;
               drawLog.push_back(cur);
               if (haveFall && lowRun < minGap) minGap = lowRun;
               saved = cur;
            end else if (cur != saved) begin
               stabErr++;
            end
            lowRun = 0;
         end else begin
            if (prevDraw) haveFall = 1'b1;
            lowRun++;
         end
         prevDraw = drawSprite;
         if (frameDone) fdCount++;
         if (frameDone !== fbSwap) swapErr++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic cfgWr(input int entry, input int word, input logic [31:0] data);
      @(negedge clk);
      cfgWrite     = 1'b1;
      cfgAddr      = {entry[IDX_W-1:0], word[1:0]};
      cfgWritedata = data;
      @(negedge clk);
      cfgWrite     = 1'b0;
   endtask

   task automatic cfgRd(input int entry, input int word, output logic [31:0] data);
      @(negedge clk);
      cfgRead = 1'b1;
      cfgAddr = {entry[IDX_W-1:0], word[1:0]};
      @(negedge clk);
      cfgRead = 1'b0;
      data    = cfgReaddata;
   endtask

   task automatic applyStimulus();
      @(negedge clk);
      frameStart = 1'b1;
      @(negedge clk);
      frameStart = 1'b0;
   endtask

   // Called right after applyStimulus; returns cycles since the tick
   task automatic waitFrameDone(input int budget, output int cycles);
      cycles = 1;
      while (!frameDone && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("frameDoneSeen", {31'd0, frameDone}, 32'd1);
   endtask

   task automatic waitDrawHigh(input int budget);
      int n;
      n = 0;
      while (!drawSprite && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drawSeen", {31'd0, drawSprite}, 32'd1);
   endtask

   task automatic clearLog();
      drawLog.delete();
      rises    = 0;
      fdCount  = 0;
      minGap   = 1000;
      haveFall = 1'b0;
   endtask

   initial begin : stimulus
      logic [31:0] rd;
      int          cyc;
      int          badReads;

      rstN         = 1'b0;
      cfgWrite     = 1'b0;
      cfgRead      = 1'b0;
      cfgAddr      = '0;
      cfgWritedata = '0;
      frameStart   = 1'b0;
      repeat (3) @(negedge clk);
      rstN = 1'b1;

      // Reset state and empty table
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      checkOutput("rstDraw", {31'd0, drawSprite}, 32'd0);
      checkOutput("rstFrameDone", {31'd0, frameDone}, 32'd0);
      checkOutput("rstOverrun", {31'd0, frameOverrun}, 32'd0);
      checkOutput("rstIndex", {28'd0, curIndex}, 32'd0);
      badReads = 0;
      for (int e = 0; e < NUM_SPRITES; e++) begin
         for (int w = 0; w < 4; w++) begin
            cfgRd(e, w, rd);
            if (rd !== 32'd0) badReads++;
         end
      end
      checkOutput("rstTableReads", badReads, 32'd0);

      // Single sprite at entry 3
      $display("[TB] single sprite frame");
      cfgWr(3, 0, 32'h0014_000A);
      cfgWr(3, 1, 32'h0008_0010);
      cfgWr(3, 2, 32'h0800_0000);
      cfgWr(3, 3, 32'h8101_0003);
      cfgRd(3, 3, rd);
      checkOutput("w3Readback", rd, 32'h0101_0003);
      cfgRd(3, 0, rd);
      checkOutput("w0Readback", rd, 32'h0014_000A);
      clearLog();
      applyStimulus();
      checkOutput("busyAfterStart", {31'd0, busy}, 32'd1);
      waitFrameDone(3000, cyc);
      @(negedge clk);
      checkOutput("oneDraw", rises, 32'd1);
      if (drawLog.size() > 0) begin
         checkOutput("drawId", {16'd0, drawLog[0].id}, 32'd3);
         checkOutput("drawX", {16'd0, drawLog[0].x}, 32'd10);
         checkOutput("drawY", {16'd0, drawLog[0].y}, 32'd20);
         checkOutput("drawW", {16'd0, drawLog[0].w}, 32'd16);
         checkOutput("drawH", {16'd0, drawLog[0].h}, 32'd8);
         checkOutput("drawAddr", drawLog[0].addr, 32'h0800_0000);
         checkOutput("drawRot", {24'd0, drawLog[0].rot}, 32'd1);
      end
      checkOutput("frameDonePulses", fdCount, 32'd1);
      checkOutput("busyAfterFrame", {31'd0, busy}, 32'd0);

      // Entries 0, 5, 15 drawn; 7 has zero width and is skipped
      $display("[TB] multi sprite frame");
      cfgWr(3, 3, 32'h0000_0000);
      cfgWr(0, 1, 32'h0004_0004);
      cfgWr(0, 3, 32'h0100_0000);
      cfgWr(5, 1, 32'h0004_0004);
      cfgWr(5, 3, 32'h0100_0005);
      cfgWr(7, 1, 32'h0004_0000);
      cfgWr(7, 3, 32'h0100_0007);
      cfgWr(15, 1, 32'h0004_0004);
      cfgWr(15, 3, 32'h0100_000F);
      clearLog();
      applyStimulus();
      waitFrameDone(3000, cyc);
      @(negedge clk);
      checkOutput("threeDraws", rises, 32'd3);
      if (drawLog.size() == 3) begin
         checkOutput("order0", {16'd0, drawLog[0].id}, 32'd0);
         checkOutput("order1", {16'd0, drawLog[1].id}, 32'd5);
         checkOutput("order2", {16'd0, drawLog[2].id}, 32'd15);
      end
      checkOutput("minDrawLowGap", minGap, 32'd8);
      checkOutput("multiFramePulses", fdCount, 32'd1);

      // All entries disabled: fixed latency, no draws
      $display("[TB] empty frame");
      cfgWr(0, 3, 32'h0000_0000);
      cfgWr(5, 3, 32'h0000_0000);
      cfgWr(7, 3, 32'h0000_0000);
      cfgWr(15, 3, 32'h0000_0000);
      clearLog();
      applyStimulus();
      waitFrameDone(100, cyc);
      checkOutput("emptyLatency", cyc, 32'd17);
      checkOutput("fbSwapWithDone", {31'd0, fbSwap}, 32'd1);
      checkOutput("lastIndex", {28'd0, curIndex}, 32'd15);
      checkOutput("noOverrunYet", {31'd0, frameOverrun}, 32'd0);
      // Tick coincident with FINISH is an overrun and starts nothing
      frameStart = 1'b1;
      @(negedge clk);
      frameStart = 1'b0;
      checkOutput("finishTickOverrun", {31'd0, frameOverrun}, 32'd1);
      repeat (3) @(negedge clk);
      checkOutput("finishTickNoWalk", {31'd0, busy}, 32'd0);
      checkOutput("emptyNoDraw", rises, 32'd0);
      cfgWr(0, 3, 32'h8000_0000);
      checkOutput("overrunCleared1", {31'd0, frameOverrun}, 32'd0);

      // Frame tick during a draw
      $display("[TB] overrun during draw");
      cfgWr(0, 3, 32'h0100_0000);
      clearLog();
      applyStimulus();
      waitDrawHigh(100);
      applyStimulus();
      checkOutput("overrunSet", {31'd0, frameOverrun}, 32'd1);
      checkOutput("drawUnaffected", {31'd0, drawSprite}, 32'd1);
      waitFrameDone(3000, cyc);
      @(negedge clk);
      checkOutput("overrunOneDraw", rises, 32'd1);
      checkOutput("overrunOnePulse", fdCount, 32'd1);
      cfgWr(0, 3, 32'h8100_0000);
      checkOutput("overrunCleared2", {31'd0, frameOverrun}, 32'd0);
      cfgRd(0, 3, rd);
      checkOutput("clrBitReadsZero", rd, 32'h0100_0000);
      cfgWr(0, 3, 32'h0000_0000);

      // Host rewrites entry 5 while it is in flight
      $display("[TB] overwrite in flight");
      cfgWr(5, 0, 32'h001E_0032);
      cfgWr(5, 3, 32'h0100_0005);
      clearLog();
      applyStimulus();
      waitDrawHigh(100);
      repeat (5) @(negedge clk);
      cfgWr(5, 0, 32'h001E_0063);
      repeat (5) @(negedge clk);
      checkOutput("xHeldInFlight", {16'd0, spriteX}, 32'd50);
      waitFrameDone(3000, cyc);
      @(negedge clk);
      if (drawLog.size() > 0)
         checkOutput("oldXDrawn", {16'd0, drawLog[0].x}, 32'd50);
      checkOutput("stableWhileDrawing", stabErr, 32'd0);
      clearLog();
      applyStimulus();
      waitFrameDone(3000, cyc);
      @(negedge clk);
      if (drawLog.size() > 0)
         checkOutput("newXDrawn", {16'd0, drawLog[0].x}, 32'd99);
      else
         checkOutput("newXDrawCount", drawLog.size(), 32'd1);

      // Reset in the middle of WAIT_DONE
      $display("[TB] reset mid draw");
      applyStimulus();
      waitDrawHigh(100);
      repeat (10) @(negedge clk);
      rstN = 1'b0;
      #1;
      checkOutput("rstMidDraw", {31'd0, drawSprite}, 32'd0);
      checkOutput("rstMidBusy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      cfgRd(5, 0, rd);
      checkOutput("rstMidTableW0", rd, 32'd0);
      cfgRd(5, 3, rd);
      checkOutput("rstMidTableW3", rd, 32'd0);
      checkOutput("swapMatchesDone", swapErr, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
